button_event: RTL and testbench
===============================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: clk cycles per time-base tick (>=2).
REQ-002 SHALL have parameter LONG_TICKS, default 500: ticks held before long press (>=2).
REQ-003 SHALL have parameter DCLICK_TICKS, default 250: ticks allowed between release and second press (>=2).
REQ-004 SHALL have parameter REPEAT_TICKS, default 100: ticks between auto-repeat pulses (>=1).
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port dbnc_in  input  1  debounced, clk-synchronous button level, 1 = pressed.
REQ-008 SHALL have port press_evt  output  1  one-cycle pulse on each press.
REQ-009 SHALL have port release_evt  output  1  one-cycle pulse on each release.
REQ-010 SHALL have port single_click  output  1  one-cycle pulse for a confirmed single click.
REQ-011 SHALL have port double_click  output  1  one-cycle pulse for a confirmed double click.
REQ-012 SHALL have port long_press  output  1  one-cycle pulse when the hold reaches LONG_TICKS.
REQ-013 SHALL have port repeat_evt  output  1  one-cycle auto-repeat pulse; tied 0 when BTN_AUTOREPEAT_EN is undefined.
REQ-014 SHALL have port held  output  1  level, 1 while in LONG_HELD.

Function
REQ-015 SHALL register dbnc_in into dbnc_q; rise = dbnc_in & !dbnc_q; fall = !dbnc_in & dbnc_q.
REQ-016 SHALL register all outputs; an event detected in cycle N SHALL pulse in cycle N+1 for exactly one clk.
REQ-017 SHALL raise press_evt and release_evt on every rise and fall, regardless of FSM state.
REQ-018 SHALL generate tick, a one-cycle strobe every TICK_DIV clks; the prescaler SHALL restart at 0 on every rise or fall.
REQ-019 SHALL keep a tick counter tcnt of width $clog2(max(LONG_TICKS,DCLICK_TICKS)+1), cleared on each state transition, incremented on tick and saturating at its maximum.
REQ-020 SHALL implement states IDLE, PRESSED, WAIT_2ND, PRESSED2, LONG_HELD.
REQ-021 IDLE: rise -> PRESSED.
REQ-022 PRESSED: fall -> WAIT_2ND; else tcnt==LONG_TICKS-1 on tick -> long_press and LONG_HELD.
REQ-023 WAIT_2ND: rise -> PRESSED2; else tcnt==DCLICK_TICKS-1 on tick -> single_click and IDLE.
REQ-024 PRESSED2: fall -> double_click and IDLE; else tcnt==LONG_TICKS-1 on tick -> long_press and LONG_HELD, with no click pulse.
REQ-025 LONG_HELD: fall -> IDLE with no click pulse.
REQ-026 A simultaneous edge and threshold tick SHALL be resolved in favour of the edge.
REQ-027 Invalid state encodings SHALL recover to IDLE on the next clk.

Reset
REQ-028 reset SHALL force state IDLE, dbnc_q=0, tcnt=0, prescaler=0, repeat counter=0 and all outputs 0, mid-operation included.
REQ-029 A dbnc_in already high when reset is released SHALL NOT produce press_evt; the first rise seen after reset SHALL start operation.

Configuration
REQ-030 With BTN_AUTOREPEAT_EN defined, LONG_HELD SHALL pulse repeat_evt every REPEAT_TICKS ticks, counted from entry into LONG_HELD.
REQ-031 Without BTN_AUTOREPEAT_EN, repeat_evt SHALL be constant 0 and no repeat counter SHALL be synthesised.

Structure
REQ-032 The btn_event_state_t enum (3-bit) and the default parameter constants SHALL live in package btn_event_pkg.
REQ-033 The prescaler SHALL be sub-module tick_gen (parameter DIV; ports clk, reset, clr, tick).

Verification (TICK_DIV=4, LONG_TICKS=8, DCLICK_TICKS=5, REPEAT_TICKS=3)
REQ-034 Press 10 clk, release, idle 30 clk -> press_evt, release_evt, then single_click exactly 20 clk after release+1; no other pulse.
REQ-035 Press 10, release 8, press 10, release -> double_click 1 clk after second fall; single_click never asserted.
REQ-036 Hold 40 clk -> long_press 32 clk after rise+1, held=1 until the fall; no click pulse on release.
REQ-037 With BTN_AUTOREPEAT_EN defined, hold 80 clk -> repeat_evt every 12 clk after long_press; without it, repeat_evt stays 0.
REQ-038 Assert reset 3 clk while in PRESSED -> all outputs 0 and state IDLE; the next release causes no event.
REQ-039 Fall coincident with the LONG_TICKS threshold tick -> WAIT_2ND entered and long_press not asserted.

Source files
------------

// File: rtl/btn_event_pkg.sv
// Shared types and default timing constants for the button event decoder.
package btn_event_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    WAIT_2ND  = 3'd2,
    PRESSED2  = 3'd3,
    LONG_HELD = 3'd4
  } btn_event_state_t;

  localparam int TICK_DIV_DEFAULT     = 1000;
  localparam int LONG_TICKS_DEFAULT   = 500;
  localparam int DCLICK_TICKS_DEFAULT = 250;
  localparam int REPEAT_TICKS_DEFAULT = 100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_tick_gen.sv
// Time-base prescaler: one-cycle tick every DIV clocks, restartable via clr.
module tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_event.sv
// Button gesture decoder: press/release, single/double click, long press, hold.
// Define BTN_AUTOREPEAT_EN to enable the repeat_evt auto-repeat pulse while held.
module button_event
  import btn_event_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEFAULT,
  parameter int LONG_TICKS   = LONG_TICKS_DEFAULT,
  parameter int DCLICK_TICKS = DCLICK_TICKS_DEFAULT,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic dbnc_in,
  output logic press_evt,
  output logic release_evt,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_evt,
  output logic held
);

  localparam int TW = $clog2(max_int(LONG_TICKS, DCLICK_TICKS) + 1);

  if (TICK_DIV < 2 || LONG_TICKS < 2 || DCLICK_TICKS < 2 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("button_event: timing parameters out of range");
  end

  btn_event_state_t state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             dbnc_q, armed_q;
  logic             rise, fall, tick;
  logic             single_d, double_d, long_d;
  logic             press_q, release_q, single_q, double_q, long_q, held_q;

  // Edges are ignored until a released level has been seen since reset, so a
  // button already held across reset produces neither a press nor a release.
  assign rise = armed_q &  dbnc_in & ~dbnc_q;
  assign fall = armed_q & ~dbnc_in &  dbnc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbnc_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      dbnc_q  <= dbnc_in;
      armed_q <= armed_q | ~dbnc_in;
    end
  end

  tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (rise | fall),
    .tick (tick)
  );

  // Edges are tested before thresholds so a coincident edge always wins.
  always_comb begin
    state_d  = state_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESSED;
      end
      PRESSED: begin
        if (fall) begin
          state_d = WAIT_2ND;
        end else if (tick && tcnt_q == TW'(LONG_TICKS - 1)) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      WAIT_2ND: begin
        if (rise) begin
          state_d = PRESSED2;
        end else if (tick && tcnt_q == TW'(DCLICK_TICKS - 1)) begin
          single_d = 1'b1;
          state_d  = IDLE;
        end
      end
      PRESSED2: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end else if (tick && tcnt_q == TW'(LONG_TICKS - 1)) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tcnt_d = tcnt_q;
    if (state_d != state_q) begin
      tcnt_d = '0;
    end else if (tick && tcnt_q != {TW{1'b1}}) begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      press_q   <= rise;
      release_q <= fall;
      single_q  <= single_d;
      double_q  <= double_d;
      long_q    <= long_d;
      held_q    <= (state_d == LONG_HELD);
    end
  end

  assign press_evt    = press_q;
  assign release_evt  = release_q;
  assign single_click = single_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign held         = held_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          repeat_d, repeat_q;

  // Repeat phase restarts on entry to LONG_HELD; the releasing cycle never repeats.
  always_comb begin
    rcnt_d   = rcnt_q;
    repeat_d = 1'b0;
    if (state_q != LONG_HELD || state_d != LONG_HELD) begin
      rcnt_d = '0;
    end else if (tick) begin
      if (rcnt_q == RW'(REPEAT_TICKS - 1)) begin
        rcnt_d   = '0;
        repeat_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_evt = repeat_q;
`else
  assign repeat_evt = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event (TICK_DIV=4, LONG=8, DCLICK=5, REPEAT=3).
// Pulses are logged with the clock edge that produced them and checked against hand offsets.
module tb_button_event;
  import btn_event_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dbnc_in = 1'b0;
  logic press_evt, release_evt, single_click, double_click, long_press, repeat_evt, held;

  int edgeCnt = 0;
  int checkCount = 0;
  int passCount = 0;
  int pressQ[$], releaseQ[$], singleQ[$], doubleQ[$], longQ[$], repeatQ[$], heldQ[$];

  button_event #(
    .TICK_DIV(4), .LONG_TICKS(8), .DCLICK_TICKS(5), .REPEAT_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .dbnc_in(dbnc_in),
    .press_evt(press_evt), .release_evt(release_evt),
    .single_click(single_click), .double_click(double_click),
    .long_press(long_press), .repeat_evt(repeat_evt), .held(held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Log the edge index of every output pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (press_evt)    pressQ.push_back(edgeCnt);
      if (release_evt)  releaseQ.push_back(edgeCnt);
      if (single_click) singleQ.push_back(edgeCnt);
      if (double_click) doubleQ.push_back(edgeCnt);
      if (long_press)   longQ.push_back(edgeCnt);
      if (repeat_evt)   repeatQ.push_back(edgeCnt);
      if (held)         heldQ.push_back(edgeCnt);
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    dbnc_in = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic clearLogs();
    pressQ.delete(); releaseQ.delete(); singleQ.delete(); doubleQ.delete();
    longQ.delete(); repeatQ.delete(); heldQ.delete();
  endtask

  function automatic int entryAt(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int allOutputs();
    return int'({press_evt, release_evt, single_click, double_click, long_press, repeat_evt, held});
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int er;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", allOutputs(), 0);
    reset = 1'b0;
    applyStimulus(1'b0, 5);

    // Single click: press 10, release, idle 30.
    clearLogs(); er = edgeCnt + 1;
    applyStimulus(1'b1, 10); applyStimulus(1'b0, 30);
    checkOutput("sc_press",     entryAt(pressQ, 0), er);
    checkOutput("sc_release",   entryAt(releaseQ, 0), er + 10);
    checkOutput("sc_single",    entryAt(singleQ, 0), er + 30);
    checkOutput("sc_single_n",  singleQ.size(), 1);
    checkOutput("sc_other_n",   doubleQ.size() + longQ.size() + repeatQ.size() + heldQ.size(), 0);
    checkOutput("sc_edges_n",   pressQ.size() + releaseQ.size(), 2);

    // Double click: press 10, release 8, press 10, release.
    clearLogs(); er = edgeCnt + 1;
    applyStimulus(1'b1, 10); applyStimulus(1'b0, 8);
    applyStimulus(1'b1, 10); applyStimulus(1'b0, 30);
    checkOutput("dc_press2",    entryAt(pressQ, 1), er + 18);
    checkOutput("dc_release2",  entryAt(releaseQ, 1), er + 28);
    checkOutput("dc_double",    entryAt(doubleQ, 0), er + 28);
    checkOutput("dc_double_n",  doubleQ.size(), 1);
    checkOutput("dc_single_n",  singleQ.size(), 0);
    checkOutput("dc_long_n",    longQ.size(), 0);

    // Long press: hold 40.
    clearLogs(); er = edgeCnt + 1;
    applyStimulus(1'b1, 40); applyStimulus(1'b0, 30);
    checkOutput("lp_long",      entryAt(longQ, 0), er + 32);
    checkOutput("lp_long_n",    longQ.size(), 1);
    checkOutput("lp_held_first", entryAt(heldQ, 0), er + 32);
    checkOutput("lp_held_n",    heldQ.size(), 8);
    checkOutput("lp_release",   entryAt(releaseQ, 0), er + 40);
    checkOutput("lp_click_n",   singleQ.size() + doubleQ.size(), 0);

    // Long hold of 80: auto-repeat behaviour.
    clearLogs(); er = edgeCnt + 1;
    applyStimulus(1'b1, 80); applyStimulus(1'b0, 30);
    checkOutput("rp_long",      entryAt(longQ, 0), er + 32);
    checkOutput("rp_held_n",    heldQ.size(), 48);
`ifdef BTN_AUTOREPEAT_EN
    checkOutput("rp_repeat_n",  repeatQ.size(), 3);
    checkOutput("rp_repeat0",   entryAt(repeatQ, 0), er + 44);
    checkOutput("rp_repeat1",   entryAt(repeatQ, 1), er + 56);
    checkOutput("rp_repeat2",   entryAt(repeatQ, 2), er + 68);
`else
    checkOutput("rp_repeat_n",  repeatQ.size(), 0);
`endif
    checkOutput("rp_click_n",   singleQ.size() + doubleQ.size(), 0);

    // Release coincident with the long-press threshold tick.
    clearLogs(); er = edgeCnt + 1;
    applyStimulus(1'b1, 32); applyStimulus(1'b0, 30);
    checkOutput("tie_long_n",   longQ.size(), 0);
    checkOutput("tie_held_n",   heldQ.size(), 0);
    checkOutput("tie_release",  entryAt(releaseQ, 0), er + 32);
    checkOutput("tie_single",   entryAt(singleQ, 0), er + 52);

    // Reset while PRESSED; the release that follows must be silent.
    clearLogs();
    applyStimulus(1'b1, 10);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("mid_rst_outputs", allOutputs(), 0);
    checkOutput("mid_rst_state", int'(dut.state_q), int'(IDLE));
    reset = 1'b0;
    clearLogs();
    applyStimulus(1'b1, 5); applyStimulus(1'b0, 30);
    checkOutput("post_rst_events",
                pressQ.size() + releaseQ.size() + singleQ.size() + doubleQ.size() + longQ.size(), 0);

    // Operation resumes on the first real press.
    clearLogs(); er = edgeCnt + 1;
    applyStimulus(1'b1, 10); applyStimulus(1'b0, 30);
    checkOutput("resume_press",  entryAt(pressQ, 0), er);
    checkOutput("resume_single", entryAt(singleQ, 0), er + 30);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
